// File: rtl/ci_stream_master.sv
// Streams 16-bit samples through a custom-instruction filter.
// Ports: in_* sample stream, out_* result stream, ci_* filter side,
//        busy / timeout_err / clr_err status; clk, reset (async, active-low).
module ci_stream_master #(
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        ci_clk_en,
    output logic        ci_start,
    output logic [31:0] ci_dataa,
    output logic [31:0] ci_datab,
    input  logic [31:0] ci_result,
    input  logic        ci_done,
    output logic        busy,
    output logic        timeout_err,
    input  logic        clr_err
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [IAW:0]  IONE  = 1;
    localparam logic [OAW:0]  OONE  = 1;
    localparam logic [TW-1:0] TONE  = 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [15:0] imem [IN_DEPTH];
    logic [15:0] omem [OUT_DEPTH];
    logic [IAW:0] iwr;
    logic [IAW:0] ird;
    logic [OAW:0] owr;
    logic [OAW:0] ord;
    logic [15:0] sample;
    logic [15:0] in_head;
    logic [TW-1:0] wcnt;

    logic in_empty;
    logic in_full;
    logic out_full;
    logic in_push;
    logic in_pop;
    logic out_push;
    logic out_pop;
    logic timeout_hit;

    // Only the low half of the filter result carries data.
    logic unused_result;
    assign unused_result = ^ci_result[31:16];

    // Pointers carry one wrap bit to tell full from empty.
    assign in_empty = (iwr == ird);
    assign in_full  = (iwr[IAW] != ird[IAW]) &&
                      (iwr[IAW-1:0] == ird[IAW-1:0]);
    assign out_full = (owr[OAW] != ord[OAW]) &&
                      (owr[OAW-1:0] == ord[OAW-1:0]);

    assign in_ready  = !in_full;
    assign out_valid = (owr != ord);
    assign in_head   = imem[ird[IAW-1:0]];
    assign out_data  = out_valid ? omem[ord[OAW-1:0]] : 16'h0;

    assign in_push  = in_valid && in_ready;
    assign in_pop   = (state == ISSUE);
    assign out_push = (state == WAIT) && ci_done;
    assign out_pop  = out_valid && out_ready;

    // A done on the final WAIT cycle still counts as success.
    assign timeout_hit = (state == WAIT) && !ci_done &&
                         (wcnt == TLAST);

    assign busy      = (state != IDLE);
    assign ci_start  = (state == ISSUE);
    assign ci_clk_en = (state == ISSUE) || (state == WAIT);
    assign ci_datab  = 32'h0;

    // Operand is live only while the filter is clocked.
    always_comb begin
        ci_dataa = 32'h0;
        unique case (state)
            ISSUE:   ci_dataa = {16'h0, in_head};
            WAIT:    ci_dataa = {16'h0, sample};
            default: ci_dataa = 32'h0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (!in_empty && !out_full) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT: if (ci_done || timeout_hit) state_nx = GAP;
            GAP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iwr <= '0;
            ird <= '0;
            owr <= '0;
            ord <= '0;
        end else begin
            if (in_push)  iwr <= iwr + IONE;
            if (in_pop)   ird <= ird + IONE;
            if (out_push) owr <= owr + OONE;
            if (out_pop)  ord <= ord + OONE;
        end
    end

    always_ff @(posedge clk) begin
        if (in_push)  imem[iwr[IAW-1:0]] <= in_data;
        if (out_push) omem[owr[OAW-1:0]] <= ci_result[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample <= 16'h0;
            wcnt   <= '0;
        end else begin
            if (state == ISSUE) begin
                sample <= in_head;
                wcnt   <= '0;
            end else if (state == WAIT) begin
                wcnt <= wcnt + TONE;
            end
        end
    end

    // A fresh timeout beats a concurrent clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (clr_err) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ci_stream_master.sv
// Scoreboard bench for ci_stream_master with a latency-programmable
// filter model; results are checked by a decoupled output monitor.
module tb_ci_stream_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        ci_clk_en;
    logic        ci_start;
    logic [31:0] ci_dataa;
    logic [31:0] ci_datab;
    logic [31:0] ci_result = 32'hFFFF_FFFF;
    logic        ci_done = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic        clr_err = 1'b0;

    ci_stream_master dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready),
        .ci_clk_en(ci_clk_en), .ci_start(ci_start),
        .ci_dataa(ci_dataa), .ci_datab(ci_datab),
        .ci_result(ci_result), .ci_done(ci_done),
        .busy(busy), .timeout_err(timeout_err),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    logic [15:0] exq[$];

    int lat = 4;
    bit act = 0;
    int cnt = 0;
    bit stale = 0;
    bit gap_pend = 0;
    logic [31:0] held = 0;
    int n_start = 0;
    int prev = 0;
    bit have_prev = 0;
    bit spc_chk = 0;
    bit rnd_ready = 0;
    bit saw_full = 0;

    function automatic logic [15:0] f(input logic [15:0] x);
        if (x == 16'h1234) return 16'hABCD;
        return {x[7:0], x[15:8]} ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act_v,
                       input logic [31:0] exp_v);
        nchk++;
        if (act_v !== exp_v) begin
            nfail++;
            $display("FAIL %s: got %h expected %h",
                     name, act_v, exp_v);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Filter model: done exactly lat cycles after the start cycle.
    initial forever begin
        @(posedge clk);
        #1;
        if (!reset) stale = 1;
        if (gap_pend) begin
            gap_pend = 0;
            if (!stale) begin
                chk("gap_clk_en", ci_clk_en, 0);
                chk("gap_busy", busy, 1);
                chk("gap_out_valid", out_valid, 1);
            end
        end
        if (ci_start) begin
            chk("start_clk_en", ci_clk_en, 1);
            chk("start_datab", ci_datab, 0);
            if (spc_chk && have_prev)
                chk("issue_spacing", cyc - prev, 7);
            prev = cyc;
            have_prev = 1;
            n_start++;
            act = 1;
            cnt = 0;
            held = ci_dataa;
            stale = 0;
        end else if (act) begin
            cnt++;
            if (!stale && cnt <= 64) begin
                chk("wait_clk_en", ci_clk_en, 1);
                chk("wait_dataa", ci_dataa, held);
            end
        end
        ci_done = act && lat != 0 && cnt == lat;
        ci_result = ci_done ? {16'hBEEF, f(held[15:0])}
                            : 32'hFFFF_FFFF;
        if (ci_done) begin
            act = 0;
            gap_pend = 1;
        end
    end

    // Output monitor: every handshake pops one expectation.
    initial forever begin
        @(negedge clk);
        if (reset && out_valid && out_ready) begin
            if (exq.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_out: got %h expected none",
                         out_data);
            end else begin
                chk("out_data", out_data, exq.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] x, input bit expect_out);
        int n = 0;
        in_valid = 1;
        in_data = x;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                if (expect_out) exq.push_back(f(x));
                @(posedge clk);
                #1;
                break;
            end
            saw_full = 1;
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            n++;
            if (n > 500) begin
                chk("push_timeout", 0, 1);
                break;
            end
        end
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        in_valid = 0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exq.size() != 0 && n < bound) begin
            step(1);
            n++;
        end
        chk("drain_left", exq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        step(3);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_clk_en", ci_clk_en, 0);
        chk("rst_start", ci_start, 0);
        chk("rst_dataa", ci_dataa, 0);
        chk("rst_datab", ci_datab, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1;
        step(2);

        // single sample
        out_ready = 1;
        push(16'h1234, 1);
        drain(50);
        chk("single_dataa", held, 32'h0000_1234);
        chk("single_starts", n_start, 1);

        // back-to-back burst
        have_prev = 0;
        spc_chk = 1;
        s0 = n_start;
        for (int i = 0; i < 8; i++)
            push(16'h1000 + 16'(i * 16'h111), 1);
        drain(200);
        spc_chk = 0;
        chk("burst_starts", n_start - s0, 8);

        // backpressure
        out_ready = 0;
        s0 = n_start;
        for (int i = 0; i < 12; i++)
            push(16'h2000 + 16'(i * 16'h0203), 1);
        step(100);
        chk("bp_starts", n_start - s0, 8);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_busy", busy, 0);
        s0 = n_start;
        step(20);
        chk("bp_no_start", n_start - s0, 0);
        out_ready = 1;
        drain(300);

        // timeout
        lat = 0;
        push(16'h7777, 0);
        n = 0;
        while (!timeout_err && n < 200) begin
            step(1);
            n++;
        end
        chk("to_latency", cyc - prev, 65);
        chk("to_out_valid", out_valid, 0);
        lat = 4;
        push(16'h2468, 1);
        drain(50);
        chk("to_sticky", timeout_err, 1);
        clr_err = 1;
        step(1);
        clr_err = 0;
        chk("to_cleared", timeout_err, 0);

        // clear and new timeout on the same edge
        lat = 0;
        s0 = n_start;
        push(16'h1357, 0);
        n = 0;
        while (n_start == s0 && n < 50) begin
            step(1);
            n++;
        end
        while (cyc < prev + 64 && n < 200) begin
            step(1);
            n++;
        end
        clr_err = 1;
        step(1);
        clr_err = 0;
        chk("to_wins_clr", timeout_err, 1);
        clr_err = 1;
        step(1);
        clr_err = 0;
        chk("to_cleared2", timeout_err, 0);
        step(3);

        // reset in WAIT with buffered samples
        lat = 10;
        s0 = n_start;
        push(16'h5555, 0);
        push(16'h6666, 0);
        push(16'h7777, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(act && cnt == 2) && n < 50);
        reset = 0;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_clk_en", ci_clk_en, 0);
        chk("rw_start", ci_start, 0);
        chk("rw_dataa", ci_dataa, 0);
        chk("rw_in_ready", in_ready, 1);
        chk("rw_out_valid", out_valid, 0);
        chk("rw_out_data", out_data, 0);
        step(2);
        reset = 1;
        s0 = n_start;
        step(20);
        chk("rw_late_done", out_valid, 0);
        chk("rw_idle", busy, 0);
        chk("rw_dropped", n_start - s0, 0);

        // full/empty concurrency with random sink
        lat = 1;
        saw_full = 0;
        rnd_ready = 1;
        for (int i = 0; i < 100; i++)
            push(16'($urandom), 1);
        rnd_ready = 0;
        out_ready = 1;
        drain(2000);
        chk("rnd_saw_full", saw_full, 1);

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/ci_stream_master.md
CI_STREAM_MASTER -- requirements
Module: ci_stream_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 - IN_DEPTH, 8, input sample FIFO entries (power of 2)
 - OUT_DEPTH, 8, output result FIFO entries (power of 2)
 - TIMEOUT, 64, max WAIT cycles before abort (>=8)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
 - clk in 1 clock
 - reset in 1 reset
 - in_valid in 1 input sample offered
 - in_data in 16 signed input sample
 - in_ready out 1 input FIFO not full
 - out_valid out 1 output FIFO not empty
 - out_data out 16 head of output FIFO
 - out_ready in 1 sink accepts out_data
 - ci_clk_en out 1 custom-instruction clock enable to filter
 - ci_start out 1 custom-instruction start
 - ci_dataa out 32 operand A, {16'b0, sample}
 - ci_datab out 32 operand B, constant 0
 - ci_result in 32 filter result, [15:0] valid
 - ci_done in 1 filter operation complete
 - busy out 1 FSM not in IDLE
 - timeout_err out 1 sticky timeout flag
 - clr_err in 1 clears timeout_err
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 Input push SHALL occur on cycles with in_valid & in_ready; in_ready SHALL be 0 exactly when input FIFO holds IN_DEPTH entries.
REQ-005 Output pop SHALL occur on cycles with out_valid & out_ready; out_data SHALL be the oldest entry, stable while out_valid & !out_ready.
REQ-006 Both FIFOs SHALL support simultaneous push and pop in one cycle, including at full (pop frees slot same cycle is NOT required; push at full is ignored) and at empty (pop ignored).
REQ-007 FSM states SHALL be IDLE, ISSUE, WAIT, GAP.
REQ-008 IDLE->ISSUE SHALL occur when input FIFO non-empty and output FIFO has a free slot; otherwise remain IDLE.
REQ-009 ISSUE (1 cycle): pop input FIFO, drive ci_dataa={16'b0,sample}, ci_start=1, ci_clk_en=1; next WAIT.
REQ-010 WAIT: ci_clk_en=1, ci_start=0, ci_dataa held; on ci_done=1 push ci_result[15:0] to output FIFO and go GAP.
REQ-011 GAP (1 cycle): ci_clk_en=0, ci_start=0; next IDLE; gives filter its idle return cycle.
REQ-012 ci_clk_en SHALL be 0 in IDLE and GAP; no sample SHALL be presented while ci_clk_en=0.
REQ-013 WAIT cycle counter SHALL reset on ISSUE; if TIMEOUT WAIT cycles elapse without ci_done, set timeout_err, discard sample, go GAP.
REQ-014 ci_done outside WAIT SHALL be ignored.
REQ-015 clr_err SHALL clear timeout_err next cycle; a simultaneous new timeout SHALL win (flag stays 1).
REQ-016 At most one operation SHALL be outstanding; minimum issue-to-issue spacing SHALL be ISSUE+WAIT+GAP+IDLE cycles.
REQ-017 Throughput with a 4-cycle filter: one result per 7 cycles; first out_valid 1 cycle after ci_done.
REQ-018 busy SHALL be 1 in ISSUE, WAIT, GAP.
REQ-019 ci_datab SHALL be 0 at all times.

Reset
REQ-020 On reset low, asynchronously: FSM IDLE, both FIFOs empty, counters 0, in_ready=1, out_valid=0, out_data=0, ci_clk_en=0, ci_start=0, ci_dataa=0, busy=0, timeout_err=0.
REQ-021 Reset mid-operation SHALL drop the outstanding sample and all buffered data; ci_done after reset release with FSM IDLE SHALL be ignored.

Verification
REQ-022 Single sample: push 0x1234, filter model done 4 cycles after start returning 0x0000ABCD -> ci_dataa=0x00001234 with one-cycle ci_start, out_data=0xABCD, ci_clk_en low in GAP.
REQ-023 Burst: push 8 samples back-to-back, out_ready=1 -> in_ready drops after 8th push (if none consumed), 8 results in order, 7-cycle spacing.
REQ-024 Backpressure: out_ready=0, push 12 samples -> exactly OUT_DEPTH results buffered, FSM IDLE, no ci_start until out_ready=1.
REQ-025 Timeout: filter model never asserts done -> timeout_err=1 after 64 WAIT cycles, no output push, next sample issues normally; clr_err clears flag.
REQ-026 Reset in WAIT: assert reset low 2 cycles into WAIT -> all outputs at reset values immediately; late ci_done produces no output.
REQ-027 Full/empty concurrency: input FIFO full with in_valid=1 and ISSUE pop same cycle -> pushed sample accepted only per in_ready, no loss or duplication over 100 random samples.
